fabric_ccff_loader: RTL

Configuration-chain controller for the fle/fabric logic tiles. It accepts a bitstream as parallel words over a valid/ready stream and serializes it onto the tile's `ccff_head`. It also raises the clock-enable that gates `prog_clk` into the chain. After loading, it recirculates the chain once (`ccff_tail` → `ccff_head`) to read the chain back non-destructively and checks a CRC-8 against the CRC computed during loading. It sits between the bitstream source and the `ccff_head`/`ccff_tail` pins of one chain of CLB tiles.

---
 rtl/fabric_ccff_pkg.sv | 24 ++
 rtl/ccff_crc8.sv | 30 +++
 rtl/fabric_ccff_loader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/fabric_ccff_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_ccff_pkg
// Brief    : Shared state encoding and CRC-8 step for the CCFF chain loader.
// Revision : 1.0 - initial release
// ============================================================================
package fabric_ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2
    } state_t;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ccff_crc8.sv
`default_nettype none
// ============================================================================
// Module   : ccff_crc8
// Brief    : Bit-serial CRC-8 accumulator with synchronous clear and enable.
// Revision : 1.0 - initial release
// ============================================================================
module ccff_crc8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic       bit_i,
    output logic [7:0] crc_o
);
    import fabric_ccff_pkg::*;

    logic [7:0] crc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            crc_q <= 8'h00;
        end else if (en_i) begin
            crc_q <= crc8_step(crc_q, bit_i);
        end
    end

    assign crc_o = crc_q;

endmodule
`default_nettype wire

// File: rtl/fabric_ccff_loader.sv
`default_nettype none
// ============================================================================
// Module   : fabric_ccff_loader
// Brief    : Serialises a word stream onto a CCFF chain, then recirculates the
//            chain once and compares readback CRC-8 against the load CRC-8.
// Revision : 1.0 - initial release
// ============================================================================
module fabric_ccff_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 26,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              s_valid,
    input  logic [WORD_W-1:0] s_data,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic [CNT_W-1:0]  bit_cnt
);
    import fabric_ccff_pkg::*;

    localparam int HC_W = $clog2(WORD_W + 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [WORD_W-1:0] hold_q, hold_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic              shift_en_q, shift_en_d;
    logic              head_q, head_d;
    logic              crc_ok_q, crc_ok_d;
    logic              done_q, done_d;
    logic              load_shift, verify_active, accept, crc_clr;
    logic [7:0]        crc_load, crc_rd, crc_rd_final;
    int unsigned       remaining;

    assign load_shift    = (state_q == ST_LOAD) && (hold_cnt_q != '0);
    assign verify_active = (state_q == ST_VERIFY);
    assign s_ready       = (state_q == ST_LOAD) && (hold_cnt_q <= HC_W'(1))
                         && ((32'(bit_cnt_q) + 32'(hold_cnt_q)) < 32'(CHAIN_LEN));
    assign accept        = s_valid && s_ready;
    assign crc_clr       = (state_q == ST_IDLE) && start;
    assign crc_rd_final  = crc8_step(crc_rd, ccff_tail);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_cnt_d  = hold_cnt_q;
        crc_ok_d    = crc_ok_q;
        done_d      = 1'b0;
        bit_cnt_inc = bit_cnt_q + CNT_W'(1);
        remaining   = 0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    bit_cnt_d  = '0;
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    crc_ok_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (load_shift) begin
                    hold_d     = hold_q >> 1;
                    hold_cnt_d = hold_cnt_q - HC_W'(1);
                    bit_cnt_d  = bit_cnt_inc;
                end
                // A refill sees the post-shift count so the last word is trimmed exactly.
                if (accept) begin
                    remaining  = 32'(CHAIN_LEN) - 32'(bit_cnt_d);
                    hold_d     = s_data;
                    hold_cnt_d = (remaining < 32'(WORD_W)) ? HC_W'(remaining) : HC_W'(WORD_W);
                end
                if (32'(bit_cnt_d) == 32'(CHAIN_LEN)) begin
                    state_d   = ST_VERIFY;
                    bit_cnt_d = '0;
                end
            end
            ST_VERIFY: begin
                bit_cnt_d = bit_cnt_inc;
                if (32'(bit_cnt_inc) == 32'(CHAIN_LEN)) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    crc_ok_d  = (crc_rd_final == crc_load);
                    done_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Enable and head are registered from next-state so the gate sees a clean flop.
        shift_en_d = (state_d == ST_VERIFY) || ((state_d == ST_LOAD) && (hold_cnt_d != '0));
        head_d     = (state_d == ST_LOAD) && (hold_cnt_d != '0) && hold_d[0];
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            shift_en_q <= 1'b0;
            head_q     <= 1'b0;
            crc_ok_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            shift_en_q <= shift_en_d;
            head_q     <= head_d;
            crc_ok_q   <= crc_ok_d;
            done_q     <= done_d;
        end
    end

    ccff_crc8 u_crc_load (
        .clk   (prog_clk),
        .rst   (pReset),
        .clr_i (crc_clr),
        .en_i  (load_shift),
        .bit_i (hold_q[0]),
        .crc_o (crc_load)
    );

    ccff_crc8 u_crc_rd (
        .clk   (prog_clk),
        .rst   (pReset),
        .clr_i (crc_clr),
        .en_i  (verify_active),
        .bit_i (ccff_tail),
        .crc_o (crc_rd)
    );

    assign ccff_shift_en = shift_en_q;
    assign ccff_head     = verify_active ? ccff_tail : head_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign crc_ok        = crc_ok_q;
    assign bit_cnt       = bit_cnt_q;

endmodule
`default_nettype wire
